step_ctrl: RTL and testbench
============================

STEP_CTRL -- requirements
Module: step_ctrl

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 1000000, number of consecutive stable clk samples (20 ms at 50 MHz) before key_n is accepted; legal range 2..2^20.
REQ-002 SHALL have port clk  input  1  single clock; all state clocked on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port key_n  input  1  raw pushbutton, active-low, asynchronous to clk, bouncy.
REQ-005 SHALL have port run_mode  input  1  1 = free-run, 0 = single-step; quasi-static switch.
REQ-006 SHALL have port halt  input  1  breakpoint/stop request from the core, synchronous to clk.
REQ-007 SHALL have port cpu_en  output  1  clock-enable to the core; core advances one cycle per clk with cpu_en=1.
REQ-008 SHALL have port state  output  2  FSM encoding for LEDs: IDLE=00, RUN=01, STEP=10, HALTED=11.
REQ-009 SHALL have port key_db  output  1  debounced key level, 1 = pressed.
REQ-010 SHALL have port step_count  output  32  number of clk cycles with cpu_en=1 since reset.

Function
REQ-011 SHALL pass key_n through a 2-flop synchronizer before any other use.
REQ-012 SHALL hold a stable level (reset = released); counter clears whenever synchronized value equals stable level; increments while it differs; on reaching DEBOUNCE_CYCLES-1 stable level takes synchronized value and counter clears.
REQ-013 SHALL generate press_pulse, one cycle high, in the cycle after stable level goes released->pressed; release produces no pulse.
REQ-014 SHALL drive key_db from the stable level (inverted to active-high), registered.
REQ-015 SHALL implement Moore FSM; cpu_en = 1 exactly when state is RUN or STEP; no combinational path from inputs to cpu_en.
REQ-016 IDLE: run_mode&!halt -> RUN; run_mode&halt -> HALTED; !run_mode&press_pulse -> STEP; else stay.
REQ-017 STEP: unconditional -> IDLE after exactly one cycle (one cpu_en cycle per press).
REQ-018 RUN: halt -> HALTED (priority); else !run_mode -> IDLE; else stay; press_pulse ignored.
REQ-019 HALTED: press_pulse -> STEP (single-step past breakpoint, halt ignored); else !run_mode&!halt -> IDLE; else stay.
REQ-020 SHALL increment step_count by 1 on each clk with cpu_en=1; wraps 0xFFFFFFFF -> 0 silently.
REQ-021 Press held indefinitely SHALL yield exactly one press_pulse; a new pulse requires release then press, each debounced.
REQ-022 Bounce shorter than DEBOUNCE_CYCLES on either edge SHALL produce no level change and no pulse.
REQ-023 Latency: key_n stable-low at cycle t -> press_pulse at t+DEBOUNCE_CYCLES+3 (±1 for synchronizer phase); STEP the following cycle.

Reset
REQ-024 reset=1 SHALL asynchronously force: state=IDLE, cpu_en=0, step_count=0, key_db=0, stable level=released, debounce counter=0, synchronizer flops=1, press_pulse=0.
REQ-025 Reset asserted mid-RUN or mid-STEP SHALL drop cpu_en in the same cycle (asynchronously); a press in progress is discarded and must be re-debounced after release of reset.
REQ-026 After reset deasserts, key_n already held low SHALL be debounced and produce one press_pulse.

Verification (DEBOUNCE_CYCLES=4)
REQ-027 Reset release, run_mode=0, key_n=1 for 50 cycles -> state=00, cpu_en=0, step_count=0 throughout.
REQ-028 run_mode=0, key_n low with 2-cycle bounces then low for 20 cycles -> exactly one cpu_en pulse, state 00->10->00, step_count=1; second debounced press -> step_count=2.
REQ-029 run_mode=1 for 100 cycles, halt=0 -> cpu_en=1 from second cycle after run_mode, step_count=99 or 98 (±synchronous entry), then halt=1 -> state=11 next cycle, step_count frozen.
REQ-030 In HALTED with halt=1, one debounced press -> one cpu_en cycle (state 11->10->00->11 with run_mode=1), step_count +1.
REQ-031 Preload step_count to 0xFFFFFFFE via force, RUN 3 cycles -> step_count 0xFFFFFFFF, 0x00000000, 0x00000001.
REQ-032 Assert reset mid-RUN asynchronously (between edges) -> cpu_en=0 immediately, step_count=0, state=00; key bouncing during reset produces no pulse.

Source files
------------

// File: rtl/step_ctrl.sv
// step_ctrl: single-step / free-run clock-enable controller for a CPU core.
// Debounces a pushbutton and gates the core's clock enable through a small FSM.
//
// Ports:
//   clk        - single clock, rising edge
//   reset      - asynchronous, active-high reset
//   key_n      - raw pushbutton, active-low, asynchronous, bouncy
//   run_mode   - 1 = free-run, 0 = single-step (quasi-static switch)
//   halt       - breakpoint/stop request from the core (synchronous)
//   cpu_en     - registered clock enable to the core
//   state      - FSM state for LEDs: IDLE=00 RUN=01 STEP=10 HALTED=11
//   key_db     - debounced key level, 1 = pressed
//   step_count - number of cycles with cpu_en=1 since reset (wraps)
module step_ctrl #(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        key_n,
    input  logic        run_mode,
    input  logic        halt,
    output logic        cpu_en,
    output logic [1:0]  state,
    output logic        key_db,
    output logic [31:0] step_count
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_STEP = 2'b10,
        S_HALT = 2'b11
    } state_t;

    logic          r_sync1;
    logic          r_sync2;
    logic          r_stable;
    logic [CW-1:0] r_cnt;
    logic          r_press;
    logic          r_key_db;
    state_t        r_state;
    logic          r_cpu_en;
    logic [31:0]   r_step_count;

    // Synchronizer flops idle high so reset looks like a released key.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= key_n;
            r_sync2 <= r_sync1;
        end
    end

    // Stable level changes only after DEBOUNCE_CYCLES consecutive
    // samples that differ from it; any agreeing sample restarts the count.
    // The press pulse is set on the same edge the stable level falls, so
    // it is high during the cycle after the level change.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stable <= 1'b1;
            r_cnt    <= '0;
            r_press  <= 1'b0;
            r_key_db <= 1'b0;
        end else begin
            r_press  <= 1'b0;
            r_key_db <= ~r_stable;
            if (r_sync2 == r_stable) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_MAX) begin
                r_stable <= r_sync2;
                r_cnt    <= '0;
                r_press  <= ~r_sync2;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    // Moore FSM; cpu_en is registered from the next state so it matches
    // RUN/STEP exactly with no input-to-output path.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_cpu_en <= 1'b0;
        end else begin
            r_cpu_en <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (run_mode && !halt) begin
                        r_state  <= S_RUN;
                        r_cpu_en <= 1'b1;
                    end else if (run_mode && halt) begin
                        r_state <= S_HALT;
                    end else if (!run_mode && r_press) begin
                        r_state  <= S_STEP;
                        r_cpu_en <= 1'b1;
                    end
                end
                S_STEP: begin
                    r_state <= S_IDLE;
                end
                S_RUN: begin
                    if (halt) begin
                        r_state <= S_HALT;
                    end else if (!run_mode) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_cpu_en <= 1'b1;
                    end
                end
                S_HALT: begin
                    if (r_press) begin
                        r_state  <= S_STEP;
                        r_cpu_en <= 1'b1;
                    end else if (!run_mode && !halt) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_step_count <= '0;
        end else if (r_cpu_en) begin
            r_step_count <= r_step_count + 32'd1;
        end
    end

    assign cpu_en     = r_cpu_en;
    assign state      = r_state;
    assign key_db     = r_key_db;
    assign step_count = r_step_count;

endmodule

// File: tb/tb_step_ctrl.sv
// tb_step_ctrl: self-checking bench for step_ctrl with DEBOUNCE_CYCLES=4.
// Expected FSM state transitions are queued as stimulus is driven.
module tb_step_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        key_n = 1'b1;
    logic        run_mode = 1'b0;
    logic        halt = 1'b0;
    logic        cpu_en;
    logic [1:0]  state;
    logic        key_db;
    logic [31:0] step_count;

    int          n_checks = 0;
    int          n_fail = 0;
    int          cpu_en_cycles = 0;
    logic [1:0]  q_exp[$];
    logic [1:0]  q_obs[$];
    logic [1:0]  prev_state = 2'b00;
    logic [31:0] exp_count = 32'd0;

    step_ctrl #(.DEBOUNCE_CYCLES(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .key_n      (key_n),
        .run_mode   (run_mode),
        .halt       (halt),
        .cpu_en     (cpu_en),
        .state      (state),
        .key_db     (key_db),
        .step_count (step_count)
    );

    always #5 clk = ~clk;

    // Record every observed state change and count enabled cycles.
    always @(negedge clk) begin
        if (state !== prev_state) begin
            q_obs.push_back(state);
            prev_state = state;
        end
        if (cpu_en === 1'b1) cpu_en_cycles++;
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset();
        n_checks++;
        if (state !== 2'b00 || cpu_en !== 1'b0 ||
            step_count !== 32'd0 || key_db !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: st=%b en=%b cnt=%0d db=%b want 00 0 0 0",
                     state, cpu_en, step_count, key_db);
        end
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            n_checks++;
            if (state !== 2'b00 || cpu_en !== 1'b0 || step_count !== 32'd0) begin
                n_fail++;
                $display("FAIL idle_hold cyc %0d: st=%b en=%b cnt=%0d want 00 0 0",
                         i, state, cpu_en, step_count);
            end
        end
        n_checks++;
        if (q_obs.size() != 0) begin
            n_fail++;
            $display("FAIL idle_no_trans: got %0d transitions want 0", q_obs.size());
        end
        q_obs.delete();
    endtask

    task automatic test_single_step();
        logic [1:0] e, o;
        cpu_en_cycles = 0;
        q_exp.push_back(2'b10);
        q_exp.push_back(2'b00);
        repeat (2) begin
            key_n = 1'b0; cycles(2);
            key_n = 1'b1; cycles(2);
        end
        key_n = 1'b0; cycles(20);
        n_checks++;
        if (key_db !== 1'b1) begin
            n_fail++;
            $display("FAIL key_db_pressed: got %b want 1", key_db);
        end
        key_n = 1'b1; cycles(12);
        n_checks++;
        if (key_db !== 1'b0) begin
            n_fail++;
            $display("FAIL key_db_released: got %b want 0", key_db);
        end
        exp_count = 32'd1;
        n_checks++;
        if (cpu_en_cycles != 1 || step_count !== exp_count) begin
            n_fail++;
            $display("FAIL step1: en_cycles=%0d cnt=%0d want 1 %0d",
                     cpu_en_cycles, step_count, exp_count);
        end
        q_exp.push_back(2'b10);
        q_exp.push_back(2'b00);
        key_n = 1'b0; cycles(15);
        key_n = 1'b1; cycles(12);
        exp_count = 32'd2;
        n_checks++;
        if (cpu_en_cycles != 2 || step_count !== exp_count) begin
            n_fail++;
            $display("FAIL step2: en_cycles=%0d cnt=%0d want 2 %0d",
                     cpu_en_cycles, step_count, exp_count);
        end
        n_checks++;
        if (q_obs.size() != q_exp.size()) begin
            n_fail++;
            $display("FAIL step_seq_len: got %0d want %0d", q_obs.size(), q_exp.size());
        end
        while (q_exp.size() > 0 && q_obs.size() > 0) begin
            e = q_exp.pop_front();
            o = q_obs.pop_front();
            n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL step_seq: got %b want %b", o, e);
            end
        end
        q_exp.delete();
        q_obs.delete();
    endtask

    task automatic test_run_halt();
        logic [1:0] e, o;
        run_mode = 1'b1;
        q_exp.push_back(2'b01);
        @(negedge clk);
        n_checks++;
        if (cpu_en !== 1'b1 || state !== 2'b01) begin
            n_fail++;
            $display("FAIL run_entry: en=%b st=%b want 1 01", cpu_en, state);
        end
        cycles(99);
        n_checks++;
        if (step_count !== exp_count + 32'd99) begin
            n_fail++;
            $display("FAIL run_count: got %0d want %0d", step_count, exp_count + 32'd99);
        end
        halt = 1'b1;
        q_exp.push_back(2'b11);
        @(negedge clk);
        exp_count = exp_count + 32'd100;
        n_checks++;
        if (state !== 2'b11 || cpu_en !== 1'b0) begin
            n_fail++;
            $display("FAIL halt_entry: st=%b en=%b want 11 0", state, cpu_en);
        end
        cycles(5);
        n_checks++;
        if (step_count !== exp_count) begin
            n_fail++;
            $display("FAIL halt_frozen: got %0d want %0d", step_count, exp_count);
        end
        n_checks++;
        if (q_obs.size() != q_exp.size()) begin
            n_fail++;
            $display("FAIL run_seq_len: got %0d want %0d", q_obs.size(), q_exp.size());
        end
        while (q_exp.size() > 0 && q_obs.size() > 0) begin
            e = q_exp.pop_front();
            o = q_obs.pop_front();
            n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL run_seq: got %b want %b", o, e);
            end
        end
        q_exp.delete();
        q_obs.delete();
    endtask

    task automatic test_halted_step();
        logic [1:0] e, o;
        cpu_en_cycles = 0;
        q_exp.push_back(2'b10);
        q_exp.push_back(2'b00);
        q_exp.push_back(2'b11);
        key_n = 1'b0; cycles(15);
        key_n = 1'b1; cycles(12);
        exp_count = exp_count + 32'd1;
        n_checks++;
        if (cpu_en_cycles != 1 || step_count !== exp_count || state !== 2'b11) begin
            n_fail++;
            $display("FAIL halted_step: en_cycles=%0d cnt=%0d st=%b want 1 %0d 11",
                     cpu_en_cycles, step_count, state, exp_count);
        end
        run_mode = 1'b0;
        halt = 1'b0;
        q_exp.push_back(2'b00);
        cycles(3);
        n_checks++;
        if (q_obs.size() != q_exp.size()) begin
            n_fail++;
            $display("FAIL hstep_seq_len: got %0d want %0d", q_obs.size(), q_exp.size());
        end
        while (q_exp.size() > 0 && q_obs.size() > 0) begin
            e = q_exp.pop_front();
            o = q_obs.pop_front();
            n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL hstep_seq: got %b want %b", o, e);
            end
        end
        q_exp.delete();
        q_obs.delete();
    endtask

    task automatic test_wrap();
        logic [1:0] e, o;
        logic [31:0] want[3];
        want[0] = 32'hFFFF_FFFF;
        want[1] = 32'h0000_0000;
        want[2] = 32'h0000_0001;
        force dut.r_step_count = 32'hFFFF_FFFE;
        run_mode = 1'b1;
        q_exp.push_back(2'b01);
        @(negedge clk);
        release dut.r_step_count;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++;
            if (step_count !== want[i]) begin
                n_fail++;
                $display("FAIL wrap %0d: got %h want %h", i, step_count, want[i]);
            end
        end
        run_mode = 1'b0;
        q_exp.push_back(2'b00);
        cycles(3);
        n_checks++;
        if (q_obs.size() != q_exp.size()) begin
            n_fail++;
            $display("FAIL wrap_seq_len: got %0d want %0d", q_obs.size(), q_exp.size());
        end
        while (q_exp.size() > 0 && q_obs.size() > 0) begin
            e = q_exp.pop_front();
            o = q_obs.pop_front();
            n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL wrap_seq: got %b want %b", o, e);
            end
        end
        q_exp.delete();
        q_obs.delete();
    endtask

    task automatic test_async_reset();
        logic [1:0] e, o;
        run_mode = 1'b1;
        q_exp.push_back(2'b01);
        cycles(5);
        @(posedge clk);
        #3;
        reset = 1'b1;
        q_exp.push_back(2'b00);
        #1;
        n_checks++;
        if (cpu_en !== 1'b0 || state !== 2'b00 || step_count !== 32'd0) begin
            n_fail++;
            $display("FAIL async_reset: en=%b st=%b cnt=%0d want 0 00 0",
                     cpu_en, state, step_count);
        end
        @(negedge clk);
        run_mode = 1'b0;
        cpu_en_cycles = 0;
        repeat (4) begin
            key_n = 1'b0; cycles(3);
            key_n = 1'b1; cycles(3);
        end
        reset = 1'b0;
        cycles(20);
        n_checks++;
        if (cpu_en_cycles != 0 || key_db !== 1'b0 || state !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_bounce: en_cycles=%0d db=%b st=%b want 0 0 00",
                     cpu_en_cycles, key_db, state);
        end
        n_checks++;
        if (q_obs.size() != q_exp.size()) begin
            n_fail++;
            $display("FAIL arst_seq_len: got %0d want %0d", q_obs.size(), q_exp.size());
        end
        while (q_exp.size() > 0 && q_obs.size() > 0) begin
            e = q_exp.pop_front();
            o = q_obs.pop_front();
            n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL arst_seq: got %b want %b", o, e);
            end
        end
        q_exp.delete();
        q_obs.delete();
    endtask

    task automatic test_reset_held_key();
        logic [1:0] e, o;
        reset = 1'b1;
        key_n = 1'b0;
        cycles(3);
        reset = 1'b0;
        cpu_en_cycles = 0;
        q_exp.push_back(2'b10);
        q_exp.push_back(2'b00);
        cycles(20);
        key_n = 1'b1;
        cycles(12);
        n_checks++;
        if (cpu_en_cycles != 1 || step_count !== 32'd1) begin
            n_fail++;
            $display("FAIL held_key: en_cycles=%0d cnt=%0d want 1 1",
                     cpu_en_cycles, step_count);
        end
        n_checks++;
        if (q_obs.size() != q_exp.size()) begin
            n_fail++;
            $display("FAIL held_seq_len: got %0d want %0d", q_obs.size(), q_exp.size());
        end
        while (q_exp.size() > 0 && q_obs.size() > 0) begin
            e = q_exp.pop_front();
            o = q_obs.pop_front();
            n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL held_seq: got %b want %b", o, e);
            end
        end
        q_exp.delete();
        q_obs.delete();
    endtask

    initial begin
        cycles(3);
        test_reset();
        test_single_step();
        test_run_halt();
        test_halted_step();
        test_wrap();
        test_async_reset();
        test_reset_held_key();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
